// File: rtl/load_store_unit.sv
// Load/store unit: serialises one load or store into little-endian byte accesses
// on the shared memory-controller port and returns sign/zero-extended load results.
module load_store_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       OP_W       = 6,
  parameter logic [ADDR_W-1:0] IO_ADDR    = ADDR_W'('h30000),
  parameter logic [OP_W-1:0]   OP_ENUM_LB  = OP_W'(1),
  parameter logic [OP_W-1:0]   OP_ENUM_LH  = OP_W'(2),
  parameter logic [OP_W-1:0]   OP_ENUM_LW  = OP_W'(3),
  parameter logic [OP_W-1:0]   OP_ENUM_LBU = OP_W'(4),
  parameter logic [OP_W-1:0]   OP_ENUM_LHU = OP_W'(5),
  parameter logic [OP_W-1:0]   OP_ENUM_SB  = OP_W'(6),
  parameter logic [OP_W-1:0]   OP_ENUM_SH  = OP_W'(7),
  parameter logic [OP_W-1:0]   OP_ENUM_SW  = OP_W'(8)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              enable_from_lsb,
  input  logic              read_write_flag_from_lsb,
  input  logic [OP_W-1:0]   op_enum_from_lsb,
  input  logic [ADDR_W-1:0] address_from_lsb,
  input  logic [31:0]       data_from_lsb,
  output logic              busy_to_lsb,
  output logic              end_to_lsb,
  output logic [31:0]       data_to_lsb,
  output logic              enable_to_cdb,
  output logic [31:0]       result_to_cdb,
  input  logic              roll_back_flag_from_rob,
  input  logic              mem_grant_in,
  input  logic              io_buffer_full_in,
  input  logic [7:0]        mem_din_in,
  output logic              mem_req_out,
  output logic              mem_wr_out,
  output logic [ADDR_W-1:0] mem_a_out,
  output logic [7:0]        mem_dout_out
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              rw_q;
  logic              cancel_q;
  logic [1:0]        idx_q;
  logic [31:0]       acc_q;
  logic              rd_pend_q;

  logic       io_stall, flush_load, issue, last_byte;
  logic [1:0] cap_idx;

  function automatic logic [1:0] last_idx(input logic [OP_W-1:0] op);
    if (op == OP_ENUM_LB || op == OP_ENUM_LBU || op == OP_ENUM_SB) return 2'd0;
    else if (op == OP_ENUM_LH || op == OP_ENUM_LHU || op == OP_ENUM_SH) return 2'd1;
    return 2'd3;
  endfunction

  function automatic logic [31:0] extend(input logic [OP_W-1:0] op, input logic [31:0] v);
    if (op == OP_ENUM_LB)       return {{24{v[7]}}, v[7:0]};
    else if (op == OP_ENUM_LH)  return {{16{v[15]}}, v[15:0]};
    else if (op == OP_ENUM_LBU) return {24'h0, v[7:0]};
    else if (op == OP_ENUM_LHU) return {16'h0, v[15:0]};
    return v;
  endfunction

  // Stall compares the operation's base address, so a whole I/O store waits together.
  assign io_stall   = rw_q && io_buffer_full_in &&
                      (addr_q == IO_ADDR || addr_q == IO_ADDR + ADDR_W'(4));
  assign flush_load = roll_back_flag_from_rob && !rw_q;
  assign issue      = (state_q == S_ACCESS) && rdy_in && mem_grant_in && !io_stall && !flush_load;
  assign last_byte  = (idx_q == last_idx(op_q));
  assign cap_idx    = idx_q - 2'd1;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      unique case (state_q)
        S_IDLE: begin
          if (enable_from_lsb)
            state_d = (roll_back_flag_from_rob && !read_write_flag_from_lsb) ? S_DONE : S_ACCESS;
        end
        S_ACCESS: begin
          if (flush_load)              state_d = S_DONE;
          else if (issue && last_byte) state_d = rw_q ? S_DONE : S_WAIT;
        end
        S_WAIT:  state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      op_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rw_q      <= 1'b0;
      cancel_q  <= 1'b0;
      idx_q     <= '0;
      acc_q     <= '0;
      rd_pend_q <= 1'b0;
    end else if (rdy_in) begin
      rd_pend_q <= issue && !rw_q;
      // The byte read last cycle belongs to the index already advanced past it.
      if (rd_pend_q) acc_q[{cap_idx, 3'b000} +: 8] <= mem_din_in;
      if (issue) idx_q <= idx_q + 2'd1;
      if (flush_load && (state_q == S_ACCESS || state_q == S_WAIT)) cancel_q <= 1'b1;
      if (state_q == S_IDLE && enable_from_lsb) begin
        op_q     <= op_enum_from_lsb;
        addr_q   <= address_from_lsb;
        data_q   <= data_from_lsb;
        rw_q     <= read_write_flag_from_lsb;
        cancel_q <= roll_back_flag_from_rob && !read_write_flag_from_lsb;
        idx_q    <= '0;
        acc_q    <= '0;
      end
    end
  end

  always_comb begin
    busy_to_lsb   = (state_q != S_IDLE);
    end_to_lsb    = 1'b0;
    enable_to_cdb = 1'b0;
    data_to_lsb   = '0;
    result_to_cdb = '0;
    mem_req_out   = issue;
    mem_wr_out    = issue && rw_q;
    mem_a_out     = '0;
    mem_dout_out  = '0;
    if (state_q == S_DONE) begin
      end_to_lsb    = rdy_in;
      enable_to_cdb = rdy_in && !rw_q && !cancel_q && !roll_back_flag_from_rob;
      data_to_lsb   = extend(op_q, acc_q);
      result_to_cdb = extend(op_q, acc_q);
    end
    if (issue) begin
      mem_a_out = addr_q + ADDR_W'(idx_q);
      if (rw_q) mem_dout_out = data_q[{idx_q, 3'b000} +: 8];
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a transaction-level model predicts each byte access and
// each completion; a negedge monitor compares every access and end pulse against it.
module tb_load_store_unit;

  localparam logic [5:0] LB = 6'd1, LH = 6'd2, LW = 6'd3, LBU = 6'd4, LHU = 6'd5;
  localparam logic [5:0] SB = 6'd6, SH = 6'd7, SW = 6'd8;
  localparam logic [31:0] IO_BASE = 32'h30000;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, enable_from_lsb, read_write_flag_from_lsb;
  logic [5:0]  op_enum_from_lsb;
  logic [31:0] address_from_lsb, data_from_lsb;
  logic        busy_to_lsb, end_to_lsb, enable_to_cdb;
  logic [31:0] data_to_lsb, result_to_cdb;
  logic        roll_back_flag_from_rob, mem_grant_in, io_buffer_full_in;
  logic [7:0]  mem_din, mem_dout_out;
  logic        mem_req_out, mem_wr_out;
  logic [31:0] mem_a_out;

  load_store_unit #(
    .ADDR_W(32), .OP_W(6), .IO_ADDR(IO_BASE),
    .OP_ENUM_LB(LB), .OP_ENUM_LH(LH), .OP_ENUM_LW(LW), .OP_ENUM_LBU(LBU),
    .OP_ENUM_LHU(LHU), .OP_ENUM_SB(SB), .OP_ENUM_SH(SH), .OP_ENUM_SW(SW)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .enable_from_lsb(enable_from_lsb), .read_write_flag_from_lsb(read_write_flag_from_lsb),
    .op_enum_from_lsb(op_enum_from_lsb), .address_from_lsb(address_from_lsb),
    .data_from_lsb(data_from_lsb), .busy_to_lsb(busy_to_lsb), .end_to_lsb(end_to_lsb),
    .data_to_lsb(data_to_lsb), .enable_to_cdb(enable_to_cdb), .result_to_cdb(result_to_cdb),
    .roll_back_flag_from_rob(roll_back_flag_from_rob), .mem_grant_in(mem_grant_in),
    .io_buffer_full_in(io_buffer_full_in), .mem_din_in(mem_din),
    .mem_req_out(mem_req_out), .mem_wr_out(mem_wr_out), .mem_a_out(mem_a_out),
    .mem_dout_out(mem_dout_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // ---------------- memory model ----------------
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  logic [31:0] r_a;
  logic        r_w;
  logic [7:0]  r_d;
  initial begin
    mem_din = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_in && mem_req_out) begin
        r_a = mem_a_out; r_w = mem_wr_out; r_d = mem_dout_out;
        @(posedge clk); #1;
        if (r_w) mem[r_a] = r_d;
        else     mem_din = mem_rd(r_a);
      end
    end
  end

  // ---------------- transaction model ----------------
  typedef struct packed {logic [31:0] addr; logic wr; logic [7:0] dout;} acc_t;
  typedef struct packed {logic cdb; logic [31:0] val;} end_t;
  acc_t exp_acc[$];
  end_t exp_end[$];

  function automatic bit is_store(input logic [5:0] op);
    return op == SB || op == SH || op == SW;
  endfunction

  function automatic int n_bytes(input logic [5:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    return 4;
  endfunction

  // Little-endian assembly, then two's-complement reinterpretation for signed loads.
  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] addr);
    longint v = 0;
    int n = n_bytes(op);
    for (int i = 0; i < n; i++) v += longint'(mem_rd(addr + 32'(i))) << (8 * i);
    if ((op == LB || op == LH) && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic model_start(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                             input int n_issue, input bit no_bcast);
    acc_t a;
    end_t e;
    int n = (n_issue < 0) ? n_bytes(op) : n_issue;
    for (int i = 0; i < n; i++) begin
      a.addr = addr + 32'(i);
      a.wr   = is_store(op);
      a.dout = is_store(op) ? 8'((data >> (8 * i)) & 32'hFF) : 8'h00;
      exp_acc.push_back(a);
    end
    e.cdb = !is_store(op) && !no_bcast;
    e.val = is_store(op) ? 32'h0 : model_load(op, addr);
    exp_end.push_back(e);
  endtask

  // ---------------- monitor / compare ----------------
  int          t0 = 0, end_cyc = -1, busy_cnt = 0, cdb_cnt = 0;
  bit          end_seen = 0, io_store = 0;
  logic [31:0] end_data;
  int          req_cyc[$];
  acc_t        cur_acc;
  end_t        cur_end;

  always @(negedge clk) begin
    if (!rst_in) begin
      assert (!(enable_from_lsb && busy_to_lsb)) else $error("protocol: enable_from_lsb while busy");
      if (busy_to_lsb) busy_cnt++;
      if (enable_to_cdb) cdb_cnt++;
      if (mem_req_out) begin
        req_cyc.push_back(cyc - t0);
        check("req_needs_grant_rdy", {30'b0, mem_grant_in, rdy_in}, 32'h3);
        check("req_during_io_full", 32'(io_store && io_buffer_full_in), 32'h0);
        if (exp_acc.size() == 0) fail_now("unexpected_mem_req");
        else begin
          cur_acc = exp_acc.pop_front();
          check("mem_a", mem_a_out, cur_acc.addr);
          check("mem_wr", 32'(mem_wr_out), 32'(cur_acc.wr));
          if (cur_acc.wr) check("mem_dout", 32'(mem_dout_out), 32'(cur_acc.dout));
        end
      end
      if (end_to_lsb) begin
        end_seen = 1;
        end_cyc  = cyc - t0;
        end_data = data_to_lsb;
        if (exp_end.size() == 0) fail_now("unexpected_end");
        else begin
          cur_end = exp_end.pop_front();
          check("enable_to_cdb", 32'(enable_to_cdb), 32'(cur_end.cdb));
          if (cur_end.cdb) begin
            check("data_to_lsb", data_to_lsb, cur_end.val);
            check("result_to_cdb", result_to_cdb, cur_end.val);
          end
        end
      end else if (enable_to_cdb) fail_now("cdb_without_end");
    end
  end

  // ---------------- stimulus ----------------
  // Masks: bit k applies in cycle k (cycle 0 carries the enable).
  task automatic run(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                     input int n_issue, input bit no_bcast, input logic [31:0] goff,
                     input logic [31:0] full, input logic [31:0] rdyoff, input logic [31:0] rbm);
    model_start(op, addr, data, n_issue, no_bcast);
    io_store = is_store(op) && (addr == IO_BASE || addr == IO_BASE + 32'd4);
    end_seen = 0; end_cyc = -1; busy_cnt = 0; cdb_cnt = 0;
    req_cyc.delete();
    op_enum_from_lsb = op; address_from_lsb = addr; data_from_lsb = data;
    read_write_flag_from_lsb = is_store(op);
    @(posedge clk); #1;
    t0 = cyc;
    for (int k = 0; k < 32 && !end_seen; k++) begin
      enable_from_lsb         = (k == 0);
      mem_grant_in            = !goff[k];
      io_buffer_full_in       = full[k];
      rdy_in                  = !rdyoff[k];
      roll_back_flag_from_rob = rbm[k];
      @(posedge clk); #1;
    end
    enable_from_lsb = 0; mem_grant_in = 1; io_buffer_full_in = 0; rdy_in = 1;
    roll_back_flag_from_rob = 0;
    if (!end_seen) fail_now("timeout_waiting_for_end");
    check("pending_accesses", exp_acc.size(), 0);
    check("pending_ends", exp_end.size(), 0);
    check("busy_after_end", 32'(busy_to_lsb), 32'h0);
    io_store = 0;
  endtask

  task automatic check_outputs_zero();
    check("rst_busy", 32'(busy_to_lsb), 0);
    check("rst_end", 32'(end_to_lsb), 0);
    check("rst_cdb", 32'(enable_to_cdb), 0);
    check("rst_data", data_to_lsb, 0);
    check("rst_result", result_to_cdb, 0);
    check("rst_req_wr", {30'b0, mem_req_out, mem_wr_out}, 0);
    check("rst_addr", mem_a_out, 0);
    check("rst_dout", 32'(mem_dout_out), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst_in = 1; rdy_in = 1; enable_from_lsb = 0; read_write_flag_from_lsb = 0;
    op_enum_from_lsb = '0; address_from_lsb = '0; data_from_lsb = '0;
    roll_back_flag_from_rob = 0; mem_grant_in = 1; io_buffer_full_in = 0;
    mem[32'h1000] = 8'h78; mem[32'h1001] = 8'h56; mem[32'h1002] = 8'h34; mem[32'h1003] = 8'h12;
    mem[32'h2003] = 8'h80;
    mem[32'h3001] = 8'h34; mem[32'h3002] = 8'hF2;
    for (int i = 0; i < 4; i++) mem[32'h5000 + 32'(i)] = 8'hEE;

    repeat (3) @(posedge clk);
    #1 check_outputs_zero();
    rst_in = 0;
    #1 check_outputs_zero();

    // LW, continuous grant
    run(LW, 32'h1000, 0, -1, 0, 0, 0, 0, 0);
    check("lw_result_literal", end_data, 32'h12345678);
    check("lw_end_cycle", end_cyc, 6);
    check("lw_req_count", req_cyc.size(), 4);
    check("lw_first_req_cycle", req_cyc[0], 1);
    check("lw_last_req_cycle", req_cyc[3], 4);
    check("lw_busy_cycles", busy_cnt, 6);
    check("lw_cdb_pulses", cdb_cnt, 1);

    // byte/half loads with extension
    run(LB, 32'h2003, 0, -1, 0, 0, 0, 0, 0);
    check("lb_result_literal", end_data, 32'hFFFFFF80);
    check("lb_end_cycle", end_cyc, 3);
    run(LBU, 32'h2003, 0, -1, 0, 0, 0, 0, 0);
    check("lbu_result_literal", end_data, 32'h00000080);
    run(LH, 32'h3001, 0, -1, 0, 0, 0, 0, 0);
    check("lh_result_literal", end_data, 32'hFFFFF234);
    run(LHU, 32'h3001, 0, -1, 0, 0, 0, 0, 0);
    check("lhu_result_literal", end_data, 32'h0000F234);

    // SH with grant dropped in cycle 2
    run(SH, 32'h4000, 32'hAABBCCDD, -1, 0, 32'h4, 0, 0, 0);
    check("sh_byte0", 32'(mem_rd(32'h4000)), 32'hDD);
    check("sh_byte1", 32'(mem_rd(32'h4001)), 32'hCC);
    check("sh_req_cycle1", req_cyc[1], 3);
    check("sh_end_cycle", end_cyc, 4);
    check("sh_cdb_pulses", cdb_cnt, 0);

    // SB to the I/O port with the buffer full in cycles 1-3
    run(SB, IO_BASE, 32'h0000005A, -1, 0, 0, 32'hE, 0, 0);
    check("io_req_cycle", req_cyc[0], 4);
    check("io_end_cycle", end_cyc, 5);
    check("io_byte", 32'(mem_rd(IO_BASE)), 32'h5A);

    // store with continuous grant
    run(SB, 32'h7000, 32'h000000A5, -1, 0, 0, 0, 0, 0);
    check("sb_end_cycle", end_cyc, 2);

    // LW rolled back in cycle 2
    run(LW, 32'h1000, 0, 1, 1, 0, 0, 0, 32'h4);
    check("lw_rb_end_cycle", end_cyc, 3);
    check("lw_rb_req_count", req_cyc.size(), 1);
    check("lw_rb_cdb_pulses", cdb_cnt, 0);

    // SW rolled back in cycle 2 still completes
    run(SW, 32'h6000, 32'hCAFEF00D, -1, 0, 0, 0, 0, 32'h4);
    check("sw_rb_end_cycle", end_cyc, 5);
    check("sw_rb_byte3", 32'(mem_rd(32'h6003)), 32'hCA);
    check("sw_rb_byte0", 32'(mem_rd(32'h6000)), 32'h0D);

    // load enable together with rollback in IDLE, and rollback during DONE
    run(LW, 32'h1000, 0, 0, 1, 0, 0, 0, 32'h1);
    check("idle_rb_end_cycle", end_cyc, 1);
    check("idle_rb_req_count", req_cyc.size(), 0);
    run(LB, 32'h2003, 0, -1, 1, 0, 0, 0, 32'h8);
    check("done_rb_end_cycle", end_cyc, 3);
    check("done_rb_cdb_pulses", cdb_cnt, 0);

    // rdy_in low in cycles 2-3 of an LW
    run(LW, 32'h1000, 0, -1, 0, 0, 0, 32'hC, 0);
    check("rdy_lw_result_literal", end_data, 32'h12345678);
    check("rdy_lw_end_cycle", end_cyc, 8);

    // asynchronous reset in the middle of an SW
    model_start(SW, 32'h5000, 32'h11223344, -1, 0);
    op_enum_from_lsb = SW; address_from_lsb = 32'h5000; data_from_lsb = 32'h11223344;
    read_write_flag_from_lsb = 1;
    @(posedge clk); #1;
    t0 = cyc;
    enable_from_lsb = 1;
    @(posedge clk); #1;
    enable_from_lsb = 0;
    @(posedge clk); #3;
    rst_in = 1;
    #1 check_outputs_zero();
    exp_acc.delete();
    exp_end.delete();
    @(posedge clk); #1;
    rst_in = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sw_byte0_written", 32'(mem_rd(32'h5000)), 32'h44);
    check("rst_sw_byte1_abandoned", 32'(mem_rd(32'h5001)), 32'hEE);
    check("rst_idle_busy", 32'(busy_to_lsb), 0);
    run(LB, 32'h2003, 0, -1, 0, 0, 0, 0, 0);
    check("post_rst_lb_end_cycle", end_cyc, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
